alu_sequencer: RTL and testbench
================================

ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 SHALL have parameter Size, default 8, the operand/result width in bits.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have ports req_valid input 1, req_ready output 1, req_op input 3, req_a input Size, req_b input Size: request channel.
REQ-005 SHALL have ports alu_a output Size, alu_b output Size, alu_funct output 2: drive the combinational ALU.
REQ-006 SHALL have ports alu_out input Size, alu_zero input 1: ALU result and zero flag.
REQ-007 SHALL have ports rsp_valid output 1, rsp_ready input 1, rsp_result output Size, rsp_zero output 1, rsp_err output 1: response channel.

Function
REQ-008 SHALL encode alu_funct as 00 ADD, 01 SUB, 10 AND, 11 OR.
REQ-009 SHALL decode req_op as 000 ADD, 001 SUB, 010 AND, 011 OR, 100 EQ, 101 MUL, 110/111 illegal.
REQ-010 SHALL run the FSM states IDLE, ISSUE, MUL_STEP and RESP.
REQ-011 SHALL assert req_ready only in IDLE; a request is accepted when req_valid and req_ready are both high on a clock edge, with op and operands registered.
REQ-012 SHALL, for ADD/SUB/AND/OR, go IDLE->ISSUE->RESP: in ISSUE drive the registered operands and funct, and capture alu_out into rsp_result; rsp_valid rises 2 cycles after accept.
REQ-013 SHALL, for EQ, issue SUB and return rsp_result = zero-extended alu_zero (1 if A==B, else 0), with the same latency as REQ-012.
REQ-014 SHALL, for MUL, perform shift-add: the accumulator clears at accept; in each of Size MUL_STEP cycles i=0..Size-1, drive alu_a = accumulator, alu_b = A<<i (truncated), funct ADD, and load alu_out only when B[i]=1; the result is the low Size bits of A*B; rsp_valid rises Size+1 cycles after accept.
REQ-015 SHALL, for illegal ops, go IDLE->RESP with rsp_result = 0 and rsp_err = 1; rsp_err SHALL be 0 for all legal ops.
REQ-016 SHALL set rsp_zero = (rsp_result == 0), registered alongside rsp_result.
REQ-017 SHALL hold rsp_valid, rsp_result, rsp_zero and rsp_err stable in RESP until rsp_ready is high; it then returns to IDLE (no back-to-back bypass; req_ready rises the cycle after the handshake).
REQ-018 SHALL drive alu_a, alu_b and alu_funct to 0 outside ISSUE/MUL_STEP.
REQ-019 SHALL ignore req_valid while busy, with no loss of the in-flight operation.
REQ-020 SHALL wrap ADD/SUB/MUL modulo 2^Size, with no carry or overflow output.

Reset
REQ-021 SHALL, while rst_n is low, immediately force state IDLE, req_ready=1 (after reset), rsp_valid=0, rsp_result=0, rsp_zero=0, rsp_err=0, alu_* = 0, and clear the accumulator and bit index.
REQ-022 SHALL, when reset is asserted mid-operation (including inside MUL_STEP or RESP), abandon that operation without emitting a response.

Configuration
REQ-023 SHALL compile MUL support in when macro ALU_SEQ_MUL_EN is defined; without it, op 101 SHALL be treated as illegal per REQ-015, and the MUL_STEP state and accumulator SHALL be absent.

Structure
REQ-024 SHALL place op codes, funct codes and the FSM state encoding in shared package alu_seq_pkg.
REQ-025 SHALL split the next-state/control logic into one sub-module, alu_seq_fsm; operand, accumulator and response registers stay in alu_sequencer.

Verification (Size=8, bench models the ALU)
REQ-026 SHALL cover: ADD 200+100 -> rsp_result=44 (0x2C), rsp_zero=0, rsp_valid 2 cycles after accept.
REQ-027 SHALL cover: SUB 5-5 -> rsp_result=0, rsp_zero=1; EQ 7,7 -> result 1; EQ 7,8 -> result 0, rsp_zero=1.
REQ-028 SHALL cover: MUL 13*11 -> 143 after 9 cycles; MUL 16*16 -> 0, rsp_zero=1; when built without ALU_SEQ_MUL_EN, MUL -> rsp_err=1, result 0.
REQ-029 SHALL cover: op 110 -> rsp_err=1, result 0; then AND 0xF0,0x3C -> 0x30 with rsp_err=0.
REQ-030 SHALL cover: rsp_ready held low for 5 cycles -> outputs stable, req_ready=0, a second req_valid ignored; after release, the next request completes normally.
REQ-031 SHALL cover: rst_n pulsed low at MUL step 4 -> all outputs return to reset values immediately, and no response is emitted.

Source files
------------

// File: rtl/alu_seq_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | alu_seq_pkg : op/funct codes, FSM state encoding, decode helpers |
// | Optional MUL support via ALU_SEQ_MUL_EN.  Rev 1.0                |
// +------------------------------------------------------------------+
package alu_seq_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_EQ  = 3'b100;
  localparam logic [2:0] OP_MUL = 3'b101;

  localparam logic [1:0] FUNCT_ADD = 2'b00;
  localparam logic [1:0] FUNCT_SUB = 2'b01;
  localparam logic [1:0] FUNCT_AND = 2'b10;
  localparam logic [1:0] FUNCT_OR  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ISSUE    = 2'd1,
    ST_RESP     = 2'd2
`ifdef ALU_SEQ_MUL_EN
    , ST_MUL_STEP = 2'd3
`endif
  } state_e;

  function automatic logic op_is_illegal(input logic [2:0] op);
`ifdef ALU_SEQ_MUL_EN
    return op[2] & op[1];
`else
    return op[2] & (op[1] | op[0]);
`endif
  endfunction

  // EQ is evaluated as a subtraction and judged by the ALU zero flag
  function automatic logic [1:0] op_to_funct(input logic [2:0] op);
    case (op)
      OP_SUB:  return FUNCT_SUB;
      OP_AND:  return FUNCT_AND;
      OP_OR:   return FUNCT_OR;
      OP_EQ:   return FUNCT_SUB;
      default: return FUNCT_ADD;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_seq_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | alu_seq_if : request, ALU and response signals of the sequencer  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
interface alu_seq_if #(parameter int Size = 8);
  logic            req_valid;
  logic            req_ready;
  logic [2:0]      req_op;
  logic [Size-1:0] req_a;
  logic [Size-1:0] req_b;
  logic [Size-1:0] alu_a;
  logic [Size-1:0] alu_b;
  logic [1:0]      alu_funct;
  logic [Size-1:0] alu_out;
  logic            alu_zero;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [Size-1:0] rsp_result;
  logic            rsp_zero;
  logic            rsp_err;

  modport master (
    output req_valid, req_op, req_a, req_b, alu_out, alu_zero, rsp_ready,
    input  req_ready, alu_a, alu_b, alu_funct, rsp_valid, rsp_result, rsp_zero, rsp_err
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, alu_out, alu_zero, rsp_ready,
    output req_ready, alu_a, alu_b, alu_funct, rsp_valid, rsp_result, rsp_zero, rsp_err
  );
endinterface
`default_nettype wire

// File: rtl/alu_seq_fsm.sv
`default_nettype none
// +------------------------------------------------------------------+
// | alu_seq_fsm : sequencer state machine and multiply bit index     |
// | MUL_STEP/index exist only with ALU_SEQ_MUL_EN.  Rev 1.0          |
// +------------------------------------------------------------------+
module alu_seq_fsm
  import alu_seq_pkg::*;
#(
  parameter int Size = 8,
  localparam int IDX_W = (Size > 1) ? $clog2(Size) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  input  logic [2:0]       req_op,
  input  logic             rsp_ready,
`ifdef ALU_SEQ_MUL_EN
  output logic [IDX_W-1:0] mul_idx,
  output logic             mul_last,
`endif
  output state_e           state,
  output logic             accept
);

  state_e state_q, state_d;

`ifdef ALU_SEQ_MUL_EN
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(Size - 1);
  logic [IDX_W-1:0] idx_q, idx_d;
  assign mul_idx = idx_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
`ifdef ALU_SEQ_MUL_EN
      idx_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
`ifdef ALU_SEQ_MUL_EN
      idx_q   <= idx_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
`ifdef ALU_SEQ_MUL_EN
    idx_d    = idx_q;
    mul_last = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          accept = 1'b1;
          if (op_is_illegal(req_op)) begin
            state_d = ST_RESP;
          end
`ifdef ALU_SEQ_MUL_EN
          else if (req_op == OP_MUL) begin
            state_d = ST_MUL_STEP;
            idx_d   = '0;
          end
`endif
          else begin
            state_d = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: state_d = ST_RESP;
`ifdef ALU_SEQ_MUL_EN
      ST_MUL_STEP: begin
        if (idx_q == LAST_IDX) begin
          mul_last = 1'b1;
          state_d  = ST_RESP;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
`endif
      ST_RESP: if (rsp_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign state = state_q;

endmodule
`default_nettype wire

// File: rtl/alu_sequencer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | alu_sequencer : sequences ops onto an external ALU (shift-add MUL|
// | with ALU_SEQ_MUL_EN), holds operand/acc/response regs.  Rev 1.0  |
// +------------------------------------------------------------------+
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int Size = 8
) (
  input  logic     clk,
  input  logic     rst_n,
  alu_seq_if.slave bus
);

  localparam int IDX_W = (Size > 1) ? $clog2(Size) : 1;

  state_e          state;
  logic            accept;
  logic [2:0]      op_q, op_d;
  logic [Size-1:0] a_q, a_d, b_q, b_d;
  logic [Size-1:0] result_q, result_d;
  logic            zero_q, zero_d, err_q, err_d;
  logic            load;
  logic [Size-1:0] load_val;
  logic            load_err;

`ifdef ALU_SEQ_MUL_EN
  logic [IDX_W-1:0] mul_idx;
  logic             mul_last;
  logic [Size-1:0]  acc_q, acc_d;
`endif

  alu_seq_fsm #(.Size(Size)) u_fsm (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (bus.req_valid),
    .req_op    (bus.req_op),
    .rsp_ready (bus.rsp_ready),
`ifdef ALU_SEQ_MUL_EN
    .mul_idx   (mul_idx),
    .mul_last  (mul_last),
`endif
    .state     (state),
    .accept    (accept)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
      err_q    <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
      acc_q    <= '0;
`endif
    end else begin
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      err_q    <= err_d;
`ifdef ALU_SEQ_MUL_EN
      acc_q    <= acc_d;
`endif
    end
  end

  always_comb begin
    op_d          = op_q;
    a_d           = a_q;
    b_d           = b_q;
    result_d      = result_q;
    zero_d        = zero_q;
    err_d         = err_q;
    load          = 1'b0;
    load_val      = '0;
    load_err      = 1'b0;
    bus.alu_a     = '0;
    bus.alu_b     = '0;
    bus.alu_funct = FUNCT_ADD;
`ifdef ALU_SEQ_MUL_EN
    acc_d         = acc_q;
`endif
    case (state)
      ST_IDLE: begin
        if (accept) begin
          op_d = bus.req_op;
          a_d  = bus.req_a;
          b_d  = bus.req_b;
`ifdef ALU_SEQ_MUL_EN
          acc_d = '0;
`endif
          if (op_is_illegal(bus.req_op)) begin
            load     = 1'b1;
            load_err = 1'b1;
          end
        end
      end
      ST_ISSUE: begin
        bus.alu_a     = a_q;
        bus.alu_b     = b_q;
        bus.alu_funct = op_to_funct(op_q);
        load          = 1'b1;
        load_val      = (op_q == OP_EQ) ? Size'(bus.alu_zero) : bus.alu_out;
      end
`ifdef ALU_SEQ_MUL_EN
      ST_MUL_STEP: begin
        bus.alu_a = acc_q;
        bus.alu_b = a_q << mul_idx;
        if (b_q[mul_idx]) acc_d = bus.alu_out;
        // Final step publishes the post-add accumulator in the same cycle
        if (mul_last) begin
          load     = 1'b1;
          load_val = acc_d;
        end
      end
`endif
      default: ;
    endcase
    if (load) begin
      result_d = load_val;
      zero_d   = (load_val == '0);
      err_d    = load_err;
    end
  end

  assign bus.req_ready  = (state == ST_IDLE);
  assign bus.rsp_valid  = (state == ST_RESP);
  assign bus.rsp_result = result_q;
  assign bus.rsp_zero   = zero_q;
  assign bus.rsp_err    = err_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_sequencer.sv
`default_nettype none
// Directed self-checking bench for alu_sequencer (Size=8) with a behavioural ALU.
module tb_alu_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  logic [7:0] alu_res;

  alu_seq_if #(.Size(8)) bus ();

  alu_sequencer #(.Size(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always_comb begin
    alu_res = 8'h00;
    case (bus.alu_funct)
      2'b00: alu_res = bus.alu_a + bus.alu_b;
      2'b01: alu_res = bus.alu_a - bus.alu_b;
      2'b10: alu_res = bus.alu_a & bus.alu_b;
      2'b11: alu_res = bus.alu_a | bus.alu_b;
      default: alu_res = 8'h00;
    endcase
  end
  assign bus.alu_out  = alu_res;
  assign bus.alu_zero = (alu_res == 8'h00);

  // Issue one request and count cycles from the accept cycle to rsp_valid.
  task automatic do_req(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                        output int lat);
    int w;
    w = 0;
    while (!bus.req_ready && w < 40) begin
      @(posedge clk); #1; w++;
    end
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_a     = a;
    bus.req_b     = b;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    lat = 1;
    while (!bus.rsp_valid && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
  endtask

  task automatic pop_rsp();
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_hs: req_ready=%b rsp_valid=%b, required 1/0", bus.req_ready, bus.rsp_valid);
    end
    checks++;
    if (bus.rsp_result !== 8'h00 || bus.rsp_zero !== 1'b0 || bus.rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_rsp: result=%h zero=%b err=%b, required 00/0/0",
               bus.rsp_result, bus.rsp_zero, bus.rsp_err);
    end
    checks++;
    if (bus.alu_a !== 8'h00 || bus.alu_b !== 8'h00 || bus.alu_funct !== 2'b00) begin
      errors++;
      $display("FAIL reset_alu: a=%h b=%h funct=%b, required 0", bus.alu_a, bus.alu_b, bus.alu_funct);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_add();
    int lat;
    do_req(3'b000, 8'd200, 8'd100, lat);
    checks++;
    if (lat !== 2) begin
      errors++;
      $display("FAIL add_latency: got %0d, required 2", lat);
    end
    checks++;
    if (bus.rsp_result !== 8'h2C || bus.rsp_zero !== 1'b0 || bus.rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL add_result: result=%h zero=%b err=%b, required 2c/0/0",
               bus.rsp_result, bus.rsp_zero, bus.rsp_err);
    end
    checks++;
    if (bus.alu_a !== 8'h00 || bus.alu_b !== 8'h00 || bus.alu_funct !== 2'b00 || bus.req_ready !== 1'b0) begin
      errors++;
      $display("FAIL add_resp_idle_alu: a=%h b=%h funct=%b req_ready=%b, required 0/0/0/0",
               bus.alu_a, bus.alu_b, bus.alu_funct, bus.req_ready);
    end
    pop_rsp();
    checks++;
    if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL add_handshake: rsp_valid=%b req_ready=%b, required 0/1", bus.rsp_valid, bus.req_ready);
    end
  endtask

  task automatic test_sub_eq();
    int lat;
    do_req(3'b001, 8'd5, 8'd5, lat);
    checks++;
    if (bus.rsp_result !== 8'h00 || bus.rsp_zero !== 1'b1 || lat !== 2) begin
      errors++;
      $display("FAIL sub_5_5: result=%h zero=%b lat=%0d, required 00/1/2", bus.rsp_result, bus.rsp_zero, lat);
    end
    pop_rsp();
    do_req(3'b100, 8'd7, 8'd7, lat);
    checks++;
    if (bus.rsp_result !== 8'h01 || bus.rsp_zero !== 1'b0 || bus.rsp_err !== 1'b0 || lat !== 2) begin
      errors++;
      $display("FAIL eq_7_7: result=%h zero=%b err=%b lat=%0d, required 01/0/0/2",
               bus.rsp_result, bus.rsp_zero, bus.rsp_err, lat);
    end
    pop_rsp();
    do_req(3'b100, 8'd7, 8'd8, lat);
    checks++;
    if (bus.rsp_result !== 8'h00 || bus.rsp_zero !== 1'b1) begin
      errors++;
      $display("FAIL eq_7_8: result=%h zero=%b, required 00/1", bus.rsp_result, bus.rsp_zero);
    end
    pop_rsp();
  endtask

  task automatic test_mul();
    int lat;
`ifdef ALU_SEQ_MUL_EN
    do_req(3'b101, 8'd13, 8'd11, lat);
    checks++;
    if (bus.rsp_result !== 8'd143 || bus.rsp_err !== 1'b0 || lat !== 9) begin
      errors++;
      $display("FAIL mul_13_11: result=%0d err=%b lat=%0d, required 143/0/9", bus.rsp_result, bus.rsp_err, lat);
    end
    pop_rsp();
    do_req(3'b101, 8'd16, 8'd16, lat);
    checks++;
    if (bus.rsp_result !== 8'd0 || bus.rsp_zero !== 1'b1) begin
      errors++;
      $display("FAIL mul_16_16: result=%0d zero=%b, required 0/1", bus.rsp_result, bus.rsp_zero);
    end
    pop_rsp();
`else
    do_req(3'b101, 8'd13, 8'd11, lat);
    checks++;
    if (bus.rsp_result !== 8'd0 || bus.rsp_err !== 1'b1 || lat !== 1) begin
      errors++;
      $display("FAIL mul_disabled: result=%0d err=%b lat=%0d, required 0/1/1", bus.rsp_result, bus.rsp_err, lat);
    end
    pop_rsp();
`endif
  endtask

  task automatic test_illegal();
    int lat;
    do_req(3'b110, 8'hAA, 8'h55, lat);
    checks++;
    if (bus.rsp_result !== 8'h00 || bus.rsp_err !== 1'b1 || bus.rsp_zero !== 1'b1 || lat !== 1) begin
      errors++;
      $display("FAIL illegal_110: result=%h err=%b zero=%b lat=%0d, required 00/1/1/1",
               bus.rsp_result, bus.rsp_err, bus.rsp_zero, lat);
    end
    pop_rsp();
    do_req(3'b010, 8'hF0, 8'h3C, lat);
    checks++;
    if (bus.rsp_result !== 8'h30 || bus.rsp_err !== 1'b0 || bus.rsp_zero !== 1'b0) begin
      errors++;
      $display("FAIL and_after_illegal: result=%h err=%b zero=%b, required 30/0/0",
               bus.rsp_result, bus.rsp_err, bus.rsp_zero);
    end
    pop_rsp();
  endtask

  task automatic test_backpressure();
    int lat;
    do_req(3'b011, 8'h0F, 8'h30, lat);
    bus.req_valid = 1'b1;
    bus.req_op    = 3'b000;
    bus.req_a     = 8'h01;
    bus.req_b     = 8'h01;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_result !== 8'h3F || bus.rsp_err !== 1'b0 || bus.req_ready !== 1'b0) begin
        errors++;
        $display("FAIL hold_cycle%0d: valid=%b result=%h err=%b req_ready=%b, required 1/3f/0/0",
                 i, bus.rsp_valid, bus.rsp_result, bus.rsp_err, bus.req_ready);
      end
    end
    bus.req_valid = 1'b0;
    pop_rsp();
    checks++;
    if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL hold_release: req_ready=%b rsp_valid=%b, required 1/0", bus.req_ready, bus.rsp_valid);
    end
    do_req(3'b001, 8'd10, 8'd3, lat);
    checks++;
    if (bus.rsp_result !== 8'd7 || lat !== 2) begin
      errors++;
      $display("FAIL after_hold_sub: result=%0d lat=%0d, required 7/2", bus.rsp_result, lat);
    end
    pop_rsp();
  endtask

  task automatic test_reset_mid();
    int lat;
    int seen;
    do_req(3'b000, 8'd1, 8'd2, lat);
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.rsp_valid !== 1'b0 || bus.rsp_result !== 8'h00 || bus.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_resp: valid=%b result=%h req_ready=%b, required 0/00/1",
               bus.rsp_valid, bus.rsp_result, bus.req_ready);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
`ifdef ALU_SEQ_MUL_EN
    bus.req_valid = 1'b1;
    bus.req_op    = 3'b101;
    bus.req_a     = 8'd13;
    bus.req_b     = 8'd11;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.alu_a !== 8'h00 || bus.alu_b !== 8'h00 || bus.rsp_valid !== 1'b0 ||
        bus.req_ready !== 1'b1 || bus.rsp_zero !== 1'b0 || bus.rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_in_mul: a=%h b=%h valid=%b req_ready=%b zero=%b err=%b, required 0/0/0/1/0/0",
               bus.alu_a, bus.alu_b, bus.rsp_valid, bus.req_ready, bus.rsp_zero, bus.rsp_err);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
`endif
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (bus.rsp_valid === 1'b1) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL no_rsp_after_reset: rsp_valid seen %0d cycles, required 0", seen);
    end
  endtask

  initial begin
    bus.req_valid = 1'b0;
    bus.req_op    = 3'b000;
    bus.req_a     = 8'h00;
    bus.req_b     = 8'h00;
    bus.rsp_ready = 1'b0;
    test_reset();
    test_add();
    test_sub_eq();
    test_mul();
    test_illegal();
    test_backpressure();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
